// File: rtl/muldiv_seq_if.sv
// EX-stage <-> mul/div sequencer signal bundle: operation request, HI/LO
// moves, flush, and the architectural HI/LO plus status returned to the pipe.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             hilo_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;
  logic             stall;

  modport master (
    output start, op, src_a, src_b, cancel, mthi, mtlo, wdata, hilo_req,
    input  hi, lo, busy, done, div0, stall
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, mthi, mtlo, wdata, hilo_req,
    output hi, lo, busy, done, div0, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply and
// restoring divide on magnitudes, with sign fix-up on the final RUN edge.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_srca, r_srcb;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_res, r_neg_rem, r_div0;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_is_div, w_signed, w_a_neg, w_b_neg, w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_trial;
  logic [2*WIDTH:0]   w_shl;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [WIDTH-1:0]   w_q, w_r, w_rem_mag;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_a_neg  = w_signed & r_srca[WIDTH-1];
  assign w_b_neg  = w_signed & r_srcb[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -r_srca : r_srca;
  assign w_b_mag  = w_b_neg ? -r_srcb : r_srcb;
  assign w_last   = (r_state == RUN) && (r_cnt == '0);

  // Multiply step: lower half holds the remaining multiplier bits.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide step: the extra top bit of w_shl keeps the shifted remainder exact.
  assign w_shl     = {r_acc, 1'b0};
  assign w_trial   = w_shl[2*WIDTH:WIDTH] - {1'b0, r_b};
  assign w_div_nxt = w_trial[WIDTH] ? w_shl[2*WIDTH-1:0]
                                    : {w_trial[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};

  assign w_acc_nxt = w_is_div ? w_div_nxt : w_mul_nxt;
  assign w_prod    = r_neg_res ? -w_acc_nxt : w_acc_nxt;
  assign w_q       = r_neg_res ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
  assign w_rem_mag = w_acc_nxt[2*WIDTH-1:WIDTH];
  assign w_r       = r_neg_rem ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start && !bus.cancel) w_state_nxt = PREP;
      PREP: w_state_nxt = bus.cancel ? IDLE : RUN;
      RUN:  if (bus.cancel)  w_state_nxt = IDLE;
            else if (w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_srca    <= '0;
      r_srcb    <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mthi) r_hi <= bus.wdata;
          if (bus.mtlo) r_lo <= bus.wdata;
          if (bus.start && !bus.cancel) begin
            r_op   <= bus.op;
            r_srca <= bus.src_a;
            r_srcb <= bus.src_b;
          end
        end
        PREP: begin
          r_cnt     <= CW'(WIDTH - 1);
          r_neg_res <= w_a_neg ^ w_b_neg;
          r_neg_rem <= w_a_neg;
          r_div0    <= w_is_div && (r_srcb == '0);
          if (w_is_div) begin
            r_acc <= {{WIDTH{1'b0}}, w_a_mag};
            r_b   <= w_b_mag;
          end else begin
            r_acc <= {{WIDTH{1'b0}}, w_b_mag};
            r_b   <= w_a_mag;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - 1'b1;
          // A flush on the final edge leaves HI/LO untouched.
          if (w_last && !bus.cancel) begin
            if (w_is_div && r_div0) begin
              r_hi <= r_srca;
              r_lo <= '1;
            end else if (w_is_div) begin
              r_hi <= w_r;
              r_lo <= w_q;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = (r_state == DONE);
  assign bus.div0  = (r_state == DONE) && r_div0;
  assign bus.stall = bus.hilo_req & bus.busy;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed/unsigned results, div-by-0,
// cancel, reset mid-op, MTHI/MTLO gating and stall.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  muldiv_seq_if #(.WIDTH(32)) bus ();
  muldiv_seq #(.WIDTH(32)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one op; lat = cycles from the start cycle to done (60 = timed out).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy1);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0;
    busy1 = bus.busy;
    lat = 1;
    while (!bus.done && lat < 60) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.cancel = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0; bus.hilo_req = 1;
    rst = 1; tick(); tick(); #1;
    n_total++; if ({bus.hi, bus.lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo}); else n_pass++;
    n_total++; if ({bus.busy, bus.done, bus.div0, bus.stall} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.div0, bus.stall}); else n_pass++;
    bus.hilo_req = 0; rst = 0; tick();
  endtask

  task automatic test_mul();
    int lat; logic b1;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, b1);
    n_total++; if (b1 !== 1'b1) $display("FAIL multu_busy_t1 got %b want 1", b1); else n_pass++;
    n_total++; if (lat != 34) $display("FAIL multu_latency got %0d want 34", lat); else n_pass++;
    n_total++; if ({bus.hi, bus.lo, bus.div0} !== {64'hFFFFFFFE_00000001, 1'b0}) $display("FAIL multu_result got %h_%h div0=%b want fffffffe_00000001 div0=0", bus.hi, bus.lo, bus.div0); else n_pass++;
    tick();
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat, b1);
    n_total++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_neg got %h_%h want ffffffff_ffffffeb", bus.hi, bus.lo); else n_pass++;
    tick();
    run_op(2'b00, 32'h80000000, 32'h80000000, lat, b1);
    n_total++; if ({bus.hi, bus.lo} !== 64'h40000000_00000000) $display("FAIL mult_min got %h_%h want 40000000_00000000", bus.hi, bus.lo); else n_pass++;
    tick();
  endtask

  task automatic test_div();
    int lat; logic b1;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, b1);
    n_total++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg got hi=%h lo=%h want hi=ffffffff lo=fffffffd", bus.hi, bus.lo); else n_pass++;
    n_total++; if (lat != 34) $display("FAIL div_latency got %0d want 34", lat); else n_pass++;
    tick();
    run_op(2'b11, 32'd100, 32'd7, lat, b1);
    n_total++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) $display("FAIL divu got hi=%h lo=%h want hi=2 lo=e", bus.hi, bus.lo); else n_pass++;
    tick();
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, b1);
    n_total++; if ({bus.hi, bus.lo} !== 64'h00000000_80000000) $display("FAIL div_ovf got hi=%h lo=%h want hi=0 lo=80000000", bus.hi, bus.lo); else n_pass++;
    tick();
  endtask

  task automatic test_div0();
    int lat; logic b1;
    run_op(2'b11, 32'd100, 32'd0, lat, b1);
    n_total++; if (lat != 34 || bus.div0 !== 1'b1) $display("FAIL div0_flag got lat=%0d div0=%b want 34 1", lat, bus.div0); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== {32'd100, 32'hFFFFFFFF}) $display("FAIL div0_result got hi=%h lo=%h want hi=64 lo=ffffffff", bus.hi, bus.lo); else n_pass++;
    bus.start = 1; bus.op = 2'b01; bus.src_a = 3; bus.src_b = 5;
    tick();
    bus.start = 0;
    n_total++; if (bus.busy !== 1'b0 || bus.div0 !== 1'b0) $display("FAIL done_start_ignored got busy=%b div0=%b want 0 0", bus.busy, bus.div0); else n_pass++;
    tick();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL done_start_still_idle got busy=%b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_cancel();
    int seen;
    bus.mthi = 1; bus.wdata = 32'h1234; tick(); bus.mthi = 0;
    bus.mtlo = 1; bus.wdata = 32'h5678; tick(); bus.mtlo = 0;
    n_total++; if ({bus.hi, bus.lo} !== {32'h1234, 32'h5678}) $display("FAIL mthi_mtlo got hi=%h lo=%h want 1234 5678", bus.hi, bus.lo); else n_pass++;
    bus.start = 1; bus.op = 2'b01; bus.src_a = 3; bus.src_b = 5;
    tick(); bus.start = 0;
    for (int i = 0; i < 9; i++) tick();
    bus.cancel = 1; tick(); bus.cancel = 0;
    n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL cancel_idle got busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
    seen = 0;
    for (int i = 0; i < 30; i++) begin if (bus.done) seen++; tick(); end
    n_total++; if (seen != 0 || {bus.hi, bus.lo} !== {32'h1234, 32'h5678}) $display("FAIL cancel_no_write got done_cycles=%0d hi=%h lo=%h want 0 1234 5678", seen, bus.hi, bus.lo); else n_pass++;
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 19; i++) tick();
    rst = 1; tick(); rst = 0;
    n_total++; if ({bus.hi, bus.lo} !== 64'h0 || bus.busy !== 1'b0) $display("FAIL rst_midop got hi=%h lo=%h busy=%b want 0 0 0", bus.hi, bus.lo, bus.busy); else n_pass++;
    tick();
  endtask

  task automatic test_stall_mtlo();
    int lat;
    bus.start = 1; bus.op = 2'b01; bus.src_a = 3; bus.src_b = 5;
    tick(); bus.start = 0;
    bus.hilo_req = 1; #1;
    n_total++; if (bus.stall !== 1'b1) $display("FAIL stall_busy got %b want 1", bus.stall); else n_pass++;
    bus.hilo_req = 0; #1;
    n_total++; if (bus.stall !== 1'b0) $display("FAIL stall_drop got %b want 0", bus.stall); else n_pass++;
    bus.mtlo = 1; bus.wdata = 32'hDEAD; tick(); bus.mtlo = 0;
    n_total++; if (bus.lo !== 32'h0) $display("FAIL mtlo_busy got lo=%h want 0", bus.lo); else n_pass++;
    lat = 2;
    while (!bus.done && lat < 60) begin tick(); lat++; end
    n_total++; if (lat != 34 || {bus.hi, bus.lo} !== {32'd0, 32'd15}) $display("FAIL multu_small got lat=%0d hi=%h lo=%h want 34 0 f", lat, bus.hi, bus.lo); else n_pass++;
    tick();
    bus.hilo_req = 1; #1;
    n_total++; if (bus.stall !== 1'b0) $display("FAIL stall_idle got %b want 0", bus.stall); else n_pass++;
    bus.hilo_req = 0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_cancel();
    test_stall_mtlo();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It sits beside the combinational ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-step shift-add or restoring-divide loop. Results go to the architectural HI/LO registers.
- Raises a stall request while the pipeline touches HI/LO or issues a new mul/div during an operation.
- Also services MTHI/MTLO writes and pipeline flush (cancel).

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin an operation, sampled only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- src_a  in  WIDTH  rs value (multiplicand / dividend)
- src_b  in  WIDTH  rt value (multiplier / divisor)
- cancel  in  1  pipeline flush; aborts any operation in progress
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- hilo_req  in  1  EX/ID instruction reads HI/LO or is a mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when HI/LO take a new result
- div0  out  1  high with done when a DIV/DIVU had src_b=0
- stall  out  1  combinational, equals hilo_req & busy

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, div0=0; the counter and internal registers are cleared. Reset mid-operation aborts it with no done pulse.
- States: IDLE, PREP, RUN, DONE.
- IDLE: start=1 & cancel=0 at edge t latches op, src_a and src_b, then goes to PREP.
- PREP (cycle t+1): for signed ops, takes magnitudes of both operands and records result sign and remainder sign (the remainder sign is the dividend sign). Loads counter=WIDTH-1, then goes to RUN.
- RUN (cycles t+2 .. t+WIDTH+1): one iteration per cycle.
  - Multiply: if accumulator bit0=1, add the multiplicand to the upper half, then shift the 2*WIDTH accumulator right.
  - Divide: shift {rem,quot} left, trial-subtract the divisor, and keep the result if non-negative with quotient bit=1.
  - The counter decrements each cycle. On the edge with counter=0, sign correction is applied, hi/lo are written and the state goes to DONE.
- DONE (cycle t+WIDTH+2 = t+34 at default): done=1 and new hi/lo are visible. The state goes to IDLE on the next edge.
  - A start in DONE is ignored, because busy=1.
- Latency: done is high exactly WIDTH+2 cycles after the cycle start was accepted. Back-to-back ops give a minimum start-to-start spacing of WIDTH+3.
- Results:
  - MULT/MULTU: {hi,lo} = the 64-bit product, two's complement for MULT.
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero: the sequence and latency are unchanged. The result is hi=src_a and lo=0xFFFFFFFF for both DIV and DIVU, and div0=1 during the DONE cycle.
- cancel:
  - In PREP/RUN/DONE, cancel forces IDLE on the next edge. hi/lo are not written, done=0 and div0=0.
  - If cancel coincides with the final RUN edge, cancel wins and hi/lo are unchanged.
  - In IDLE, cancel with start drops the start.
- mthi/mtlo:
  - Accepted only when busy=0, and written on that edge; ignored while busy.
  - mthi/mtlo together with start in IDLE: the write happens, the start is accepted, and the later result overwrites.
- start while busy is ignored. op, src_a and src_b are don't-care after acceptance.
- stall is purely combinational from hilo_req and busy, with no registered delay.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF accepted at cycle t -> busy rises at t+1, done at t+34, hi=0xFFFFFFFE, lo=0x00000001, div0=0.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100 / 7 -> lo=14, hi=2. Then DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> done with div0=1, hi=100, lo=0xFFFFFFFF. Then a second start on the DONE cycle -> ignored, busy falls next cycle.
- Preload via mthi=0x1234, mtlo=0x5678; start MULTU 3 x 5; assert cancel at t+10 -> IDLE at t+11, no done, hi=0x1234, lo=0x5678. Repeat with rst at t+20 -> hi=lo=0, busy=0.
- During a busy op, pulse hilo_req -> stall=1 in the same cycle. mtlo during busy -> lo unchanged. hilo_req in IDLE -> stall=0.
